// File: rtl/fff_pkg.sv
// -----------------------------------------------------------------------------
// fff_pkg -- shared definitions for the quiz-buzzer winner decoder.
//   state_e      : round-control FSM encoding
//   CODE_*       : priority-encoder codes presented on code_in
//   SEG_DIGIT*   : active-low 7-segment patterns {a,b,c,d,e,f,g} for 1..4
//   seg_for_id() : maps a player index to the pattern for digit index+1
// -----------------------------------------------------------------------------
package fff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_QUAL   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic [3:0] CODE_NONE = 4'b1111;
  localparam logic [3:0] CODE_P0   = 4'b1110;
  localparam logic [3:0] CODE_P1   = 4'b1101;
  localparam logic [3:0] CODE_P2   = 4'b1100;
  localparam logic [3:0] CODE_P3   = 4'b1011;

  // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT1 = 7'b1001111;
  localparam logic [6:0] SEG_DIGIT2 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT3 = 7'b0000110;
  localparam logic [6:0] SEG_DIGIT4 = 7'b1001100;

  function automatic logic [6:0] seg_for_id(input logic [1:0] id);
    logic [6:0] seg;
    case (id)
      2'd0:    seg = SEG_DIGIT1;
      2'd1:    seg = SEG_DIGIT2;
      2'd2:    seg = SEG_DIGIT3;
      2'd3:    seg = SEG_DIGIT4;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/code_qualifier.sv
// -----------------------------------------------------------------------------
// code_qualifier -- decodes the buzzer priority-encoder code and checks that a
// player code stays identical for STABLE_CYCLES consecutive samples.
//   clk, rst   : clock, synchronous active-high reset
//   i_code     : raw code from the priority encoder
//   i_hunt     : FSM is in ARMED (waiting for a first player code)
//   i_qual     : FSM is in QUAL (candidate captured, counting)
//   o_accept   : one-cycle pulse, candidate stable long enough -> lock
//   o_start    : a player code seen while hunting -> go to QUAL
//   o_drop     : candidate broken while qualifying -> back to ARMED
//   o_id       : decoded player index of the current sample
// -----------------------------------------------------------------------------
module code_qualifier
  import fff_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_code,
  input  logic       i_hunt,
  input  logic       i_qual,
  output logic       o_accept,
  output logic       o_start,
  output logic       o_drop,
  output logic [1:0] o_id
);

  localparam logic [3:0] LAST_COUNT = 4'(STABLE_CYCLES - 1);
  localparam bit         ONE_SHOT   = (STABLE_CYCLES == 1);

  logic       w_is_player;
  logic [1:0] w_id;
  logic       w_match;
  logic [1:0] r_cand;
  logic [3:0] r_count;

  // Code decode; invalid codes behave exactly like "no player".
  always_comb begin
    w_is_player = 1'b1;
    w_id        = 2'd0;
    case (i_code)
      CODE_P0: w_id = 2'd0;
      CODE_P1: w_id = 2'd1;
      CODE_P2: w_id = 2'd2;
      CODE_P3: w_id = 2'd3;
      default: w_is_player = 1'b0;
    endcase
  end

  assign w_match  = w_is_player && (w_id == r_cand);
  // r_count holds samples already seen, so the current sample is the last one
  // needed when r_count == STABLE_CYCLES-1.
  assign o_accept = (i_hunt && w_is_player && ONE_SHOT) ||
                    (i_qual && w_match && (r_count == LAST_COUNT));
  assign o_start  = i_hunt && w_is_player;
  assign o_drop   = i_qual && !w_match;
  assign o_id     = w_id;

  // Candidate capture and stability counter; cleared whenever not counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand  <= 2'd0;
      r_count <= 4'd0;
    end else if (o_start) begin
      r_cand  <= w_id;
      r_count <= 4'd1;
    end else if (i_qual && w_match) begin
      r_count <= r_count + 4'd1;
    end else begin
      r_count <= 4'd0;
    end
  end

endmodule

// File: rtl/winner_decoder.sv
// -----------------------------------------------------------------------------
// winner_decoder -- quiz-buzzer round controller. Locks the first player whose
// code is stable for STABLE_CYCLES samples, lights its lamp and drives the
// buzzer for BUZZ_CYCLES cycles.
//   clk, rst     : clock, synchronous active-high reset
//   code_in      : priority-encoder code (1111 none, 1110..1011 players 0..3)
//   arm / clear  : host opens / closes a round (clear wins over arm)
//   armed        : round open and no winner yet
//   winner_valid : winner locked
//   winner_lamp  : one-hot lamp of the winner, zero otherwise
//   winner_id    : index of the winner, zero otherwise
//   buzzer       : buzzer drive
//   seg_n        : active-low 7-segment display of winner_id+1, only present
//                  when WINNER_DECODER_SEG7_EN is defined
// -----------------------------------------------------------------------------
module winner_decoder
  import fff_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BUZZ_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code_in,
  input  logic       arm,
  input  logic       clear,
  output logic       armed,
  output logic       winner_valid,
  output logic [3:0] winner_lamp,
  output logic [1:0] winner_id,
  output logic       buzzer
`ifdef WINNER_DECODER_SEG7_EN
  ,
  output logic [6:0] seg_n
`endif
);

  localparam logic [15:0] BUZZ_LEN = 16'(BUZZ_CYCLES);

  state_e      r_state;
  state_e      w_next;
  logic        w_hunt;
  logic        w_qual;
  logic        w_accept;
  logic        w_start;
  logic        w_drop;
  logic [1:0]  w_id;
  logic        r_armed;
  logic        r_valid;
  logic [3:0]  r_lamp;
  logic [1:0]  r_id;
  logic        r_buzzer;
  logic [15:0] r_buzz_cnt;

  // clear gates the qualifier so a lock can never race a clear.
  assign w_hunt = (r_state == ST_ARMED) && !clear;
  assign w_qual = (r_state == ST_QUAL)  && !clear;

  code_qualifier #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_qual (
    .clk      (clk),
    .rst      (rst),
    .i_code   (code_in),
    .i_hunt   (w_hunt),
    .i_qual   (w_qual),
    .o_accept (w_accept),
    .o_start  (w_start),
    .o_drop   (w_drop),
    .o_id     (w_id)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) w_next = ST_ARMED;
          else     w_next = ST_IDLE;
        end
        ST_ARMED: begin
          if (w_accept)     w_next = ST_LOCKED;
          else if (w_start) w_next = ST_QUAL;
          else              w_next = ST_ARMED;
        end
        ST_QUAL: begin
          if (w_accept)    w_next = ST_LOCKED;
          else if (w_drop) w_next = ST_ARMED;
          else             w_next = ST_QUAL;
        end
        ST_LOCKED: w_next = ST_LOCKED;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Registered outputs and buzzer timer. r_buzz_cnt counts cycles the buzzer
  // has already been high and stops at BUZZ_LEN, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_valid    <= 1'b0;
      r_lamp     <= 4'b0000;
      r_id       <= 2'b00;
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= 16'd0;
    end else begin
      r_armed <= (w_next == ST_ARMED) || (w_next == ST_QUAL);
      r_valid <= (w_next == ST_LOCKED);
      if (w_accept) begin
        r_lamp     <= 4'(4'b0001 << w_id);
        r_id       <= w_id;
        r_buzzer   <= 1'b1;
        r_buzz_cnt <= 16'd1;
      end else if (w_next != ST_LOCKED) begin
        r_lamp     <= 4'b0000;
        r_id       <= 2'b00;
        r_buzzer   <= 1'b0;
        r_buzz_cnt <= 16'd0;
      end else if (r_buzzer) begin
        if (r_buzz_cnt >= BUZZ_LEN) begin
          r_buzzer <= 1'b0;
        end else begin
          r_buzz_cnt <= r_buzz_cnt + 16'd1;
        end
      end
    end
  end

  assign armed        = r_armed;
  assign winner_valid = r_valid;
  assign winner_lamp  = r_lamp;
  assign winner_id    = r_id;
  assign buzzer       = r_buzzer;

`ifdef WINNER_DECODER_SEG7_EN
  logic [6:0] r_seg_n;

  // Display register: digit of the winner while locked, blank otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_n <= SEG_BLANK;
    end else if (w_accept) begin
      r_seg_n <= seg_for_id(w_id);
    end else if (w_next != ST_LOCKED) begin
      r_seg_n <= SEG_BLANK;
    end
  end

  assign seg_n = r_seg_n;
`endif

endmodule

// File: tb/tb_winner_decoder.sv
// -----------------------------------------------------------------------------
// tb_winner_decoder -- directed bench for winner_decoder with a behavioural
// round model (run length of identical player codes, buzzer countdown) that is
// compared against the DUT every cycle, plus hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_winner_decoder;

  localparam int STABLE = 4;
  localparam int BUZZ   = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_in;
  logic       arm;
  logic       clear;
  logic       armed;
  logic       winner_valid;
  logic [3:0] winner_lamp;
  logic [1:0] winner_id;
  logic       buzzer;
`ifdef WINNER_DECODER_SEG7_EN
  logic [6:0] seg_n;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  winner_decoder #(.STABLE_CYCLES(STABLE), .BUZZ_CYCLES(BUZZ)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .arm          (arm),
    .clear        (clear),
    .armed        (armed),
    .winner_valid (winner_valid),
    .winner_lamp  (winner_lamp),
    .winner_id    (winner_id),
    .buzzer       (buzzer)
`ifdef WINNER_DECODER_SEG7_EN
    ,
    .seg_n        (seg_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_open, m_locked;
  int m_cand, m_run, m_win, m_buzz_left;

  function automatic int player_of(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1100: return 2;
      4'b1011: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] digit_pattern(input int d);
    logic [6:0] t [4];
    t[0] = 7'b1001111; t[1] = 7'b0010010; t[2] = 7'b0000110; t[3] = 7'b1001100;
    return t[d - 1];
  endfunction

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_open = 1'b0; m_locked = 1'b0; m_run = 0; m_buzz_left = 0; m_win = 0; m_cand = 0;
    end else if (clear) begin
      m_open = 1'b0; m_locked = 1'b0; m_run = 0; m_buzz_left = 0;
    end else if (m_locked) begin
      if (m_buzz_left > 0) m_buzz_left = m_buzz_left - 1;
    end else if (m_open) begin
      p = player_of(code_in);
      if (p < 0) m_run = 0;
      else if (m_run > 0 && p == m_cand) m_run = m_run + 1;
      else if (m_run > 0) m_run = 0;
      else begin m_cand = p; m_run = 1; end
      if (m_run == STABLE) begin
        m_locked = 1'b1; m_win = m_cand; m_buzz_left = BUZZ; m_run = 0;
      end
    end else if (arm) begin
      m_open = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("armed",  armed,        32'(m_open && !m_locked));
      check("valid",  winner_valid, 32'(m_locked));
      check("lamp",   winner_lamp,  m_locked ? 32'(1 << m_win) : 32'd0);
      check("id",     winner_id,    m_locked ? 32'(m_win) : 32'd0);
      check("buzzer", buzzer,       32'(m_buzz_left > 0));
`ifdef WINNER_DECODER_SEG7_EN
      check("seg", seg_n, m_locked ? 32'(digit_pattern(m_win + 1)) : 32'h7f);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cyc(1); arm = 1'b0;
  endtask

  task automatic do_clear();
    code_in = 4'b1111; clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; arm = 1'b0; clear = 1'b0; code_in = 4'b1111;
    cyc(2);
    chk_en = 1'b1;
    check("rst_armed", armed, 0);
    check("rst_valid", winner_valid, 0);
    check("rst_buzz",  buzzer, 0);
    rst = 1'b0;
    cyc(1);

    // Scenario 1: player 1 held 4 samples, then the full buzzer pulse.
    pulse_arm();
    check("s1_armed", armed, 1);
    code_in = 4'b1101;
    cyc(3);
    check("s1_latency_early", winner_valid, 0);
    cyc(1);
    check("s1_valid", winner_valid, 1);
    check("s1_lamp", winner_lamp, 4'b0010);
    check("s1_id", winner_id, 1);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      if (buzzer) n++;
      cyc(1);
    end
    check("s1_buzz_len", n, 1000);
    check("s1_still_valid", winner_valid, 1);
    do_clear();
    check("s1_cleared", winner_valid, 0);

    // Scenario 2: run of 3 then none -> no lock; then player 3.
    pulse_arm();
    code_in = 4'b1100; cyc(3);
    code_in = 4'b1111; cyc(1);
    check("s2_nolock", winner_valid, 0);
    check("s2_armed", armed, 1);
    code_in = 4'b1011; cyc(4);
    check("s2_id", winner_id, 3);
    do_clear();

    // Scenario 3: locked on player 0 ignores code and arm; clear returns idle.
    pulse_arm();
    code_in = 4'b1110; cyc(4);
    check("s3_id0", winner_id, 0);
    code_in = 4'b1101; arm = 1'b1; cyc(2); arm = 1'b0;
    check("s3_hold_id", winner_id, 0);
    check("s3_hold_lamp", winner_lamp, 4'b0001);
    do_clear();
    check("s3_clr_valid", winner_valid, 0);
    check("s3_clr_lamp", winner_lamp, 0);
    check("s3_clr_buzz", buzzer, 0);
    check("s3_clr_armed", armed, 0);

    // A different player mid-qualification restarts the run from ARMED.
    pulse_arm();
    code_in = 4'b1110; cyc(2);
    code_in = 4'b1101; cyc(4);
    check("swap_nolock", winner_valid, 0);
    cyc(1);
    check("swap_lock", winner_valid, 1);
    check("swap_id", winner_id, 1);
    do_clear();

    // Scenario 4: invalid codes never lock; codes in IDLE do nothing.
    pulse_arm();
    code_in = 4'b0110; cyc(10);
    check("s4_invalid", winner_valid, 0);
    check("s4_armed", armed, 1);
    do_clear();
    code_in = 4'b1010; cyc(3);
    check("s4_idle", armed, 0);
    code_in = 4'b1110; cyc(5);
    check("s4_idle_player", winner_valid, 0);
    code_in = 4'b1111;

    // Scenario 5: reset mid-QUAL and mid-buzz; clear beats arm.
    pulse_arm();
    code_in = 4'b1100; cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("s5_rst_q_armed", armed, 0);
    check("s5_rst_q_valid", winner_valid, 0);
    code_in = 4'b1111;
    pulse_arm();
    code_in = 4'b1100; cyc(4);
    check("s5_locked", winner_valid, 1);
    cyc(10);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("s5_rst_b_buzz", buzzer, 0);
    check("s5_rst_b_valid", winner_valid, 0);
    check("s5_rst_b_lamp", winner_lamp, 0);
    code_in = 4'b1111;
    clear = 1'b1; arm = 1'b1; cyc(1); clear = 1'b0; arm = 1'b0;
    check("s5_clr_arm", armed, 0);
    cyc(2);

`ifdef WINNER_DECODER_SEG7_EN
    // Scenario 6: display digit 3 for player 2, blank after clear.
    pulse_arm();
    code_in = 4'b1100; cyc(4);
    check("s6_seg", seg_n, 7'b0000110);
    do_clear();
    check("s6_blank", seg_n, 7'b1111111);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/winner_decoder.md
WINNER_DECODER -- requirements
Module: winner_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive identical samples needed to accept a player code (legal range 1..15).
REQ-002 SHALL have parameter BUZZ_CYCLES, default 1000, buzzer pulse length in clk cycles (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port code_in  input  4  code from the buzzer priority encoder.
REQ-006 SHALL have port arm  input  1  host starts a round (level, sampled each edge).
REQ-007 SHALL have port clear  input  1  host ends a round and returns to idle.
REQ-008 SHALL have port armed  output  1  high while a round is open and no winner is locked.
REQ-009 SHALL have port winner_valid  output  1  high while a winner is locked.
REQ-010 SHALL have port winner_lamp  output  4  one-hot active-high lamp, bit n = player n.
REQ-011 SHALL have port winner_id  output  2  index of the locked player.
REQ-012 SHALL have port buzzer  output  1  buzzer drive, active-high.

Function
REQ-013 SHALL decode code_in: 4'b1111 = none; 4'b1110 = player 0; 4'b1101 = player 1; 4'b1100 = player 2; 4'b1011 = player 3; every other value = invalid, treated as none.
REQ-014 SHALL implement states IDLE, ARMED, QUAL and LOCKED, all transitions on the clk edge.
REQ-015 IDLE: arm=1 -> ARMED; code_in ignored.
REQ-016 ARMED: a player code -> QUAL, candidate id captured, count=1; if STABLE_CYCLES=1 -> LOCKED directly.
REQ-017 QUAL: code equals candidate -> count+1; on count reaching STABLE_CYCLES -> LOCKED; any other code, including none or invalid -> ARMED, count cleared.
REQ-018 LOCKED: state and winner held until clear; arm and code_in ignored.
REQ-019 clear=1 SHALL force IDLE from any state on the next edge and SHALL take priority over arm.
REQ-020 Latency: a code presented for samples t..t+STABLE_CYCLES-1 SHALL assert winner_valid from cycle t+STABLE_CYCLES.
REQ-021 winner_lamp and winner_id SHALL be registered, valid only while winner_valid=1, and all-zero otherwise.
REQ-022 armed SHALL be 1 in ARMED and QUAL and 0 otherwise.
REQ-023 buzzer SHALL be high for exactly BUZZ_CYCLES cycles, starting the same cycle winner_valid rises.
REQ-024 clear during the buzzer pulse SHALL drop buzzer on the next edge.
REQ-025 The buzzer counter SHALL saturate and never wrap.

Reset
REQ-026 rst=1 SHALL force state IDLE, count 0, and the buzzer counter 0.
REQ-027 Reset values: armed 0, winner_valid 0, winner_lamp 4'b0000, winner_id 2'b00, buzzer 0, seg_n 7'b1111111.
REQ-028 rst SHALL take priority over clear and arm, including when asserted mid-QUAL or mid-buzz.

Configuration
REQ-029 Macro WINNER_DECODER_SEG7_EN SHALL, when defined, add output port seg_n (7 bits, active-low, segments a..g).
REQ-030 With the macro defined, seg_n SHALL display digit winner_id+1 while winner_valid=1 and be blank (7'b1111111) otherwise.
REQ-031 Without the macro, seg_n and its decode logic SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-032 The shared package fff_pkg SHALL hold:
- the state encoding type;
- code constants CODE_NONE, CODE_P0..CODE_P3;
- the 7-segment digit patterns for digits 1..4.
REQ-033 Sub-module code_qualifier SHALL contain the code decode and the stability counter, and output a one-cycle accept pulse plus the id.
REQ-034 The FSM, buzzer timer and output registers SHALL live in winner_decoder.

Verification
REQ-035 Scenario 1: arm, then code 4'b1101 held for 4 cycles -> winner_valid rises in cycle 5; winner_lamp=4'b0010; winner_id=1; buzzer high for exactly 1000 cycles.
REQ-036 Scenario 2: armed, code 4'b1100 for 3 cycles, then 4'b1111 -> no lock, armed stays 1; then 4'b1011 for 4 cycles -> winner_id=3.
REQ-037 Scenario 3: locked on player 0, code_in changes to 4'b1101 and arm pulses -> winner_id stays 0; then clear -> next cycle IDLE, all outputs 0.
REQ-038 Scenario 4: invalid code 4'b0110 held 10 cycles while armed -> no lock; code 4'b1010 presented in IDLE -> no state change.
REQ-039 Scenario 5: rst asserted at count 2 in QUAL, and again mid-buzz -> next cycle all outputs at reset values; clear and arm asserted together in IDLE -> stays IDLE.
REQ-040 Scenario 6: with WINNER_DECODER_SEG7_EN defined, lock on player 2 -> seg_n shows digit 3 (7'b0000110); after clear -> seg_n=7'b1111111.
